// File: rtl/div_seq_unit_if.sv
// Request/response bundle for the sequential divider.
// Master issues operands, slave returns the registered result.
interface div_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed,
    output dividend, divisor,
    input  busy, done,
    input  quotient, remainder,
    input  div_by_zero
  );

  modport slave (
    input  start, is_signed,
    input  dividend, divisor,
    output busy, done,
    output quotient, remainder,
    output div_by_zero
  );
endinterface

// File: rtl/div_seq_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) with busy/done handshake.
// One quotient bit per cycle on magnitudes, sign fix-up in a final state.
module div_seq_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  div_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             sgn;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             dvs_zero;
  logic [WIDTH:0]   a_sh;
  logic             ge;
  logic [WIDTH-1:0] a_sub;

  assign sgn      = SIGNED_EN && bus.is_signed;
  assign dvd_neg  = sgn && bus.dividend[WIDTH-1];
  assign dvs_neg  = sgn && bus.divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? (~bus.dividend + 1'b1)
                            : bus.dividend;
  assign dvs_mag  = dvs_neg ? (~bus.divisor + 1'b1)
                            : bus.divisor;
  assign dvs_zero = (bus.divisor == '0);

  assign a_sh  = {a_q, q_q[WIDTH-1]};
  assign ge    = (a_sh >= {1'b0, dvs_q});
  // Difference fits in WIDTH bits whenever ge holds.
  assign a_sub = a_sh[WIDTH-1:0] - dvs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = dvs_zero ? FIX : RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    dvs_d  = dvs_q;
    dvd_d  = dvd_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    divz_d = divz_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    done_d = (state_q == FIX);
    busy_d = (state_q != IDLE) || bus.start;

    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          a_d    = '0;
          q_d    = dvd_mag;
          dvs_d  = dvs_mag;
          dvd_d  = bus.dividend;
          cnt_d  = CW'(WIDTH);
          qneg_d = dvd_neg ^ dvs_neg;
          rneg_d = dvd_neg;
          dz_d   = dvs_zero;
        end
      end
      (state_q == RUN): begin
        a_d   = ge ? a_sub : a_sh[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - 1'b1;
      end
      (state_q == FIX): begin
        divz_d = dz_q;
        if (dz_q) begin
          quo_d = '1;
          rem_d = dvd_q;
        end else begin
          quo_d = qneg_q ? (~q_q + 1'b1) : q_q;
          rem_d = rneg_q ? (~a_q + 1'b1) : a_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = divz_q;
endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit: 32-bit and 8-bit instances.
// Inputs driven and outputs sampled on the falling edge.
module tb_div_seq_unit;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  div_seq_unit_if #(.WIDTH(32)) b32 ();
  div_seq_unit_if #(.WIDTH(8))  b8 ();

  div_seq_unit #(
    .WIDTH(32),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(b32)
  );

  div_seq_unit #(
    .WIDTH(8),
    .SIGNED_EN(1'b1)
  ) dut8 (
    .clk(clk),
    .reset(reset),
    .bus(b8)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic op32(
    input string       tag,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          exp_at,
    input logic [31:0] eq,
    input logic [31:0] er,
    input logic        edz,
    input int          pulse_at
  );
    int at;
    bit bok;
    at  = -1;
    bok = 1'b1;
    b32.is_signed = sg;
    b32.dividend  = a;
    b32.divisor   = b;
    b32.start     = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) b32.start = 1'b0;
      if (pulse_at > 0 && c == pulse_at) begin
        b32.start    = 1'b1;
        b32.dividend = 32'd1000;
        b32.divisor  = 32'd3;
      end
      if (pulse_at > 0 && c == pulse_at + 1)
        b32.start = 1'b0;
      if (!b32.busy) bok = 1'b0;
      if (b32.done) begin
        at = c;
        break;
      end
    end
    chk({tag, ".cyc"}, at, exp_at);
    chk({tag, ".q"}, b32.quotient, eq);
    chk({tag, ".r"}, b32.remainder, er);
    chk({tag, ".dz"}, b32.div_by_zero, edz);
    chk({tag, ".busy"}, bok, 1'b1);
    @(negedge clk);
    chk({tag, ".done1"}, b32.done, 1'b0);
    chk({tag, ".idle"}, b32.busy, 1'b0);
  endtask

  initial begin
    int   d1;
    int   d2;
    bit   bok;
    bit   seen;
    logic [7:0] q1, r1, q2, r2;

    reset = 1'b1;
    b32.start = 1'b0;
    b32.is_signed = 1'b0;
    b32.dividend = '0;
    b32.divisor = '0;
    b8.start = 1'b0;
    b8.is_signed = 1'b0;
    b8.dividend = '0;
    b8.divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst.busy", b32.busy, 1'b0);
    chk("rst.done", b32.done, 1'b0);
    chk("rst.q", b32.quotient, 32'h0);
    chk("rst.r", b32.remainder, 32'h0);
    chk("rst.dz", b32.div_by_zero, 1'b0);
    chk("rst.busy8", b8.busy, 1'b0);

    op32("u100/7", 1'b0, 32'd100, 32'd7,
         34, 32'd14, 32'd2, 1'b0, 0);
    op32("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h2,
         34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    op32("s7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE,
         34, 32'hFFFF_FFFD, 32'h1, 1'b0, 0);
    op32("dz", 1'b0, 32'd5, 32'd0,
         2, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    op32("dzclr", 1'b0, 32'd100, 32'd7,
         34, 32'd14, 32'd2, 1'b0, 0);
    op32("smin", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
         34, 32'h8000_0000, 32'h0, 1'b0, 0);
    op32("umin", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
         34, 32'h0, 32'h8000_0000, 1'b0, 0);
    op32("pulse", 1'b0, 32'd100, 32'd7,
         34, 32'd14, 32'd2, 1'b0, 10);

    // Abort a running op with reset in cycle 12.
    b32.is_signed = 1'b0;
    b32.dividend  = 32'd100;
    b32.divisor   = 32'd7;
    b32.start     = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) b32.start = 1'b0;
      if (c == 12) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", b32.busy, 1'b0);
    chk("abort.q", b32.quotient, 32'h0);
    chk("abort.r", b32.remainder, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b32.done || b32.busy) seen = 1'b1;
    end
    chk("abort.nodone", seen, 1'b0);
    op32("9/3", 1'b0, 32'd9, 32'd3,
         34, 32'd3, 32'd0, 1'b0, 0);

    // Reset and start together: reset wins.
    reset         = 1'b1;
    b32.dividend  = 32'd9;
    b32.divisor   = 32'd3;
    b32.start     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    b32.start = 1'b0;
    chk("rststart.q", b32.quotient, 32'h0);
    @(negedge clk);
    chk("rststart.busy", b32.busy, 1'b0);

    // 8-bit: 255/16 then back-to-back 200/7.
    d1  = -1;
    d2  = -1;
    bok = 1'b1;
    q1  = '0;
    r1  = '0;
    q2  = '0;
    r2  = '0;
    b8.dividend = 8'd255;
    b8.divisor  = 8'd16;
    b8.start    = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) b8.start = 1'b0;
      if (d1 > 0 && c == d1 + 1) b8.start = 1'b0;
      if (!b8.busy) bok = 1'b0;
      if (b8.done && d1 > 0) begin
        d2 = c;
        q2 = b8.quotient;
        r2 = b8.remainder;
        break;
      end
      if (b8.done && d1 < 0) begin
        d1 = c;
        q1 = b8.quotient;
        r1 = b8.remainder;
        b8.dividend = 8'd200;
        b8.divisor  = 8'd7;
        b8.start    = 1'b1;
      end
    end
    b8.start = 1'b0;
    chk("w8.cyc1", d1, 10);
    chk("w8.q1", q1, 8'd15);
    chk("w8.r1", r1, 8'd15);
    chk("w8.cyc2", d2, 20);
    chk("w8.q2", q2, 8'd28);
    chk("w8.r2", r2, 8'd4);
    chk("w8.busy", bok, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
